ahb_output_stage_param: RTL and testbench

Parametrised AHB-Lite output stage for the bus matrix. It routes one of `NPORTS` input-stage ports to a single shared slave, with configurable address and data widths. It contains an internal arbiter that counts burst beats and holds locked sequences, so fixed-length bursts are never split. It sits between the input stages and the slave port, in place of the per-slave, hard-wired two-port output stages.

---
 rtl/ahb_output_stage_param.sv | 198 +++++++++++++++++++
 tb/tb_ahb_output_stage_param.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_output_stage_param.sv
// AHB-Lite output stage: arbitrates NPORTS input stages onto one shared slave.
// Define AHB_OS_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (port 0 highest).

module ahb_output_stage_param #(
   parameter int NPORTS = 4,
   parameter int AW     = 32,
   parameter int DW     = 32
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic [NPORTS-1:0]   sel_op,
   input  logic [NPORTS-1:0]   held_tran_op,
   input  logic [NPORTS*AW-1:0] addr_op,
   input  logic [2*NPORTS-1:0] trans_op,
   input  logic [NPORTS-1:0]   write_op,
   input  logic [3*NPORTS-1:0] size_op,
   input  logic [3*NPORTS-1:0] burst_op,
   input  logic [4*NPORTS-1:0] prot_op,
   input  logic [4*NPORTS-1:0] master_op,
   input  logic [NPORTS-1:0]   mastlock_op,
   input  logic [DW*NPORTS-1:0] wdata_op,
   input  logic                HREADYOUTM,
   output logic [NPORTS-1:0]   active_op,
   output logic                HSELM,
   output logic [AW-1:0]       HADDRM,
   output logic [1:0]          HTRANSM,
   output logic                HWRITEM,
   output logic [2:0]          HSIZEM,
   output logic [2:0]          HBURSTM,
   output logic [3:0]          HPROTM,
   output logic [3:0]          HMASTERM,
   output logic                HMASTLOCKM,
   output logic                HREADYMUXM,
   output logic [DW-1:0]       HWDATAM
);

   localparam int PW = $clog2(NPORTS);

   localparam logic [1:0] TRN_IDLE = 2'b00;
   localparam logic [1:0] TRN_BUSY = 2'b01;
   localparam logic [1:0] TRN_NSEQ = 2'b10;
   localparam logic [1:0] TRN_SEQ  = 2'b11;
   localparam logic [2:0] BRST_INCR = 3'b001;

   logic [AW-1:0] addr_arr   [NPORTS];
   logic [1:0]    trans_arr  [NPORTS];
   logic [2:0]    size_arr   [NPORTS];
   logic [2:0]    burst_arr  [NPORTS];
   logic [3:0]    prot_arr   [NPORTS];
   logic [3:0]    master_arr [NPORTS];
   logic [DW-1:0] wdata_arr  [NPORTS];

   for (genvar g = 0; g < NPORTS; g++) begin : g_unpack
      assign addr_arr[g]   = addr_op[g*AW +: AW];
      assign trans_arr[g]  = trans_op[g*2 +: 2];
      assign size_arr[g]   = size_op[g*3 +: 3];
      assign burst_arr[g]  = burst_op[g*3 +: 3];
      assign prot_arr[g]   = prot_op[g*4 +: 4];
      assign master_arr[g] = master_op[g*4 +: 4];
      assign wdata_arr[g]  = wdata_op[g*DW +: DW];
   end

   logic [NPORTS-1:0] req;
   logic [PW-1:0]     addr_in_port;
   logic [PW-1:0]     data_in_port;
   logic [PW-1:0]     winner;
   logic              no_port;
   logic              slave_sel;
   logic              hsel_lock;
   logic              hlock_arb;
   logic              hold;
   logic              accepted;
   logic              upd_grant;
   logic [4:0]        beat_cnt;
   logic [4:0]        beat_load;

   assign req = held_tran_op & sel_op;

   always_comb begin
      HSELM      = 1'b0;
      HADDRM     = '0;
      HTRANSM    = TRN_IDLE;
      HWRITEM    = 1'b0;
      HSIZEM     = '0;
      HBURSTM    = '0;
      HPROTM     = '0;
      HMASTERM   = '0;
      HMASTLOCKM = 1'b0;
      active_op  = '0;
      if (!no_port) begin
         HSELM      = sel_op[addr_in_port];
         HADDRM     = addr_arr[addr_in_port];
         HTRANSM    = trans_arr[addr_in_port];
         HWRITEM    = write_op[addr_in_port];
         HSIZEM     = size_arr[addr_in_port];
         HBURSTM    = burst_arr[addr_in_port];
         HPROTM     = prot_arr[addr_in_port];
         HMASTERM   = master_arr[addr_in_port];
         HMASTLOCKM = mastlock_op[addr_in_port];
         active_op[addr_in_port] = 1'b1;
      end
   end

   assign HREADYMUXM = slave_sel ? HREADYOUTM : 1'b1;
   assign HWDATAM    = wdata_arr[data_in_port];

   always_comb begin
      case (HBURSTM)
         3'b010, 3'b011: beat_load = 5'd3;
         3'b100, 3'b101: beat_load = 5'd7;
         3'b110, 3'b111: beat_load = 5'd15;
         default:        beat_load = 5'd0;
      endcase
   end

   assign accepted  = HREADYMUXM & HSELM;
   assign hlock_arb = HMASTLOCKM & (hsel_lock | HSELM);

   // The NONSEQ of a fixed-length burst also holds, so the grant cannot move
   // on the very edge that loads the beat counter.
   assign hold = (beat_cnt != 5'd0)
               | (((HTRANSM == TRN_BUSY) | (HTRANSM == TRN_SEQ)) & (HBURSTM == BRST_INCR))
               | hlock_arb
               | (accepted & (HTRANSM == TRN_NSEQ) & (beat_load != 5'd0));

   assign upd_grant = HREADYMUXM & ~hold;

`ifdef AHB_OS_ROUND_ROBIN_EN
   logic [PW-1:0] rr_ptr;

   always_comb begin
      int  idx;
      logic found;
      idx    = 0;
      found  = 1'b0;
      winner = rr_ptr;
      for (int k = 1; k <= NPORTS; k++) begin
         idx = (int'(rr_ptr) + k) % NPORTS;
         if (!found && req[idx]) begin
            winner = PW'(idx);
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         rr_ptr <= PW'(NPORTS - 1);
      else if (upd_grant && (|req))
         rr_ptr <= winner;
   end
`else
   always_comb begin
      winner = '0;
      for (int k = NPORTS - 1; k >= 0; k--)
         if (req[k]) winner = PW'(k);
   end
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_in_port <= '0;
         no_port      <= 1'b1;
      end else if (upd_grant) begin
         if (|req) begin
            addr_in_port <= winner;
            no_port      <= 1'b0;
         end else begin
            no_port      <= 1'b1;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         data_in_port <= '0;
         slave_sel    <= 1'b0;
         hsel_lock    <= 1'b0;
         beat_cnt     <= '0;
      end else if (HREADYMUXM) begin
         data_in_port <= addr_in_port;
         slave_sel    <= HSELM;
         if (!HMASTLOCKM)
            hsel_lock <= 1'b0;
         else if (HSELM && HTRANSM[1])
            hsel_lock <= 1'b1;
         if (accepted) begin
            case (HTRANSM)
               TRN_NSEQ: beat_cnt <= beat_load;
               TRN_SEQ:  if (beat_cnt != 5'd0) beat_cnt <= beat_cnt - 5'd1;
               TRN_IDLE: beat_cnt <= '0;
               default:  ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ahb_output_stage_param.sv
// Bench for ahb_output_stage_param: directed scenarios plus random traffic against a transaction-level model.
// Honours AHB_OS_ROUND_ROBIN_EN the same way the design does.

module tb_ahb_output_stage_param;

   localparam int NP = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic HCLK = 1'b0;
   logic HRESETn = 1'b0;
   always #5 HCLK = ~HCLK;

   logic [NP-1:0]    sel_op, held_tran_op, write_op, mastlock_op;
   logic [NP*AW-1:0] addr_op;
   logic [2*NP-1:0]  trans_op;
   logic [3*NP-1:0]  size_op, burst_op;
   logic [4*NP-1:0]  prot_op, master_op;
   logic [DW*NP-1:0] wdata_op;
   logic             HREADYOUTM;

   logic [NP-1:0] active_op;
   logic          HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM;
   logic [AW-1:0] HADDRM;
   logic [1:0]    HTRANSM;
   logic [2:0]    HSIZEM, HBURSTM;
   logic [3:0]    HPROTM, HMASTERM;
   logic [DW-1:0] HWDATAM;

   ahb_output_stage_param #(.NPORTS(NP), .AW(AW), .DW(DW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .sel_op(sel_op), .held_tran_op(held_tran_op), .addr_op(addr_op),
      .trans_op(trans_op), .write_op(write_op), .size_op(size_op),
      .burst_op(burst_op), .prot_op(prot_op), .master_op(master_op),
      .mastlock_op(mastlock_op), .wdata_op(wdata_op), .HREADYOUTM(HREADYOUTM),
      .active_op(active_op), .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM),
      .HWRITEM(HWRITEM), .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM),
      .HMASTERM(HMASTERM), .HMASTLOCKM(HMASTLOCKM), .HREADYMUXM(HREADYMUXM),
      .HWDATAM(HWDATAM)
   );

   int checks = 0;
   int errors = 0;

   // transaction-level model state
   int m_port, m_dport, m_ptr, m_beats;
   bit m_none, m_ssel, m_lock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int beats_of(input int b);
      if (b < 2) return 0;
      return (4 << ((b - 2) / 2)) - 1;
   endfunction

   function automatic int pick();
      logic [NP-1:0] r;
      r = sel_op & held_tran_op;
`ifdef AHB_OS_ROUND_ROBIN_EN
      for (int k = 1; k <= NP; k++)
         if (r[(m_ptr + k) % NP]) return (m_ptr + k) % NP;
`else
      for (int k = 0; k < NP; k++)
         if (r[k]) return k;
`endif
      return 0;
   endfunction

   task automatic model_reset();
      m_port = 0; m_dport = 0; m_ptr = NP - 1; m_beats = 0;
      m_none = 1'b1; m_ssel = 1'b0; m_lock = 1'b0;
   endtask

   // compare every output against the model, then advance one clock
   task automatic step();
      logic [NP-1:0] e_act;
      logic [18:0]   e_ctrl;
      logic [AW-1:0] e_addr;
      logic [1:0]    e_trans;
      logic [2:0]    e_burst;
      logic          e_sel, e_lockm, e_ready;
      bit            hold, acc;
      int            n_port, n_ptr, n_beats;
      bit            n_none, n_lock;
      #1;
      e_act = '0; e_addr = '0; e_trans = 2'b00; e_burst = 3'b000; e_sel = 1'b0; e_lockm = 1'b0; e_ctrl = '0;
      if (!m_none) begin
         e_act[m_port] = 1'b1;
         e_sel   = sel_op[m_port];
         e_addr  = addr_op[m_port*AW +: AW];
         e_trans = trans_op[m_port*2 +: 2];
         e_burst = burst_op[m_port*3 +: 3];
         e_lockm = mastlock_op[m_port];
         e_ctrl  = {e_sel, e_trans, write_op[m_port], size_op[m_port*3 +: 3], e_burst,
                    prot_op[m_port*4 +: 4], master_op[m_port*4 +: 4], e_lockm};
      end
      e_ready = m_ssel ? HREADYOUTM : 1'b1;
      chk("m_active", 64'(active_op), 64'(e_act));
      chk("m_addr", 64'(HADDRM), 64'(e_addr));
      chk("m_ctrl", 64'({HSELM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTERM, HMASTLOCKM}), 64'(e_ctrl));
      chk("m_ready", 64'(HREADYMUXM), 64'(e_ready));
      chk("m_wdata", 64'(HWDATAM), 64'(wdata_op[m_dport*DW +: DW]));

      n_port = m_port; n_ptr = m_ptr; n_beats = m_beats; n_none = m_none; n_lock = m_lock;
      if (e_ready) begin
         acc  = e_sel;
         hold = (m_beats > 0)
             || ((e_trans == 2'b01 || e_trans == 2'b11) && e_burst == 3'b001)
             || (e_lockm && (m_lock || e_sel))
             || (acc && e_trans == 2'b10 && beats_of(int'(e_burst)) > 0);
         if (acc) begin
            if (e_trans == 2'b00) n_beats = 0;
            else if (e_trans == 2'b10) n_beats = beats_of(int'(e_burst));
            else if (e_trans == 2'b11 && m_beats > 0) n_beats = m_beats - 1;
         end
         if (!e_lockm) n_lock = 1'b0;
         else if (e_sel && e_trans[1]) n_lock = 1'b1;
         if (!hold) begin
            if ((sel_op & held_tran_op) == '0) n_none = 1'b1;
            else begin
               n_none = 1'b0;
               n_port = pick();
               n_ptr  = n_port;
            end
         end
      end
      @(posedge HCLK);
      if (HRESETn && e_ready) begin
         m_dport = m_port; m_ssel = e_sel;
         m_port = n_port; m_ptr = n_ptr; m_beats = n_beats; m_none = n_none; m_lock = n_lock;
      end
      @(negedge HCLK);
   endtask

   task automatic set_port(input int p, input bit s, input bit h, input logic [31:0] a,
                           input logic [1:0] t, input logic [2:0] b, input bit lk, input logic [31:0] wd);
      sel_op[p] = s; held_tran_op[p] = h;
      addr_op[p*AW +: AW] = a; trans_op[p*2 +: 2] = t; burst_op[p*3 +: 3] = b;
      mastlock_op[p] = lk; wdata_op[p*DW +: DW] = wd;
      write_op[p] = 1'b1; size_op[p*3 +: 3] = 3'b010; prot_op[p*4 +: 4] = 4'b0011;
      master_op[p*4 +: 4] = 4'(p);
   endtask

   task automatic clear_all();
      for (int p = 0; p < NP; p++)
         set_port(p, 1'b0, 1'b0, 32'h0, 2'b00, 3'b000, 1'b0, $urandom);
      HREADYOUTM = 1'b1;
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      clear_all();
      model_reset();
      @(negedge HCLK);
      HRESETn = 1'b1;
   endtask

   task automatic burst_hold(input int ws);
      logic [31:0] a;
      a = $urandom & 32'hFFFF_FFF0;
      do_reset();
      set_port(0, 1, 1, a, 2'b10, 3'b011, 0, $urandom);
      step();
      chk("burst_grant0", 64'(active_op), 64'(4'b0001));
      step();
      set_port(1, 1, 1, $urandom, 2'b10, 3'b000, 0, $urandom);
      for (int b = 1; b <= 3; b++) begin
         set_port(0, 1, 1, a + 32'(4*b), 2'b11, 3'b011, 0, $urandom);
         if (b == 2 && ws > 0) begin
            HREADYOUTM = 1'b0;
            for (int w = 0; w < ws; w++) begin
               step();
               chk("burst_ws_active", 64'(active_op), 64'(4'b0001));
               chk("burst_ws_ready", 64'(HREADYMUXM), 64'(1'b0));
               chk("burst_ws_addr", 64'(HADDRM), 64'(a + 32'(4*b)));
            end
            HREADYOUTM = 1'b1;
         end
         step();
         chk("burst_hold_active", 64'(active_op), 64'(4'b0001));
      end
      set_port(0, 0, 0, 32'h0, 2'b00, 3'b000, 0, $urandom);
      step();
      chk("burst_regrant1", 64'(active_op), 64'(4'b0010));
   endtask

   initial begin
      logic [3:0] exp_act;
      clear_all();
      model_reset();
      HRESETn = 1'b0;
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;
      #1;
      chk("rst_hsel", 64'(HSELM), 64'(1'b0));
      chk("rst_htrans", 64'(HTRANSM), 64'(2'b00));
      chk("rst_hready", 64'(HREADYMUXM), 64'(1'b1));
      chk("rst_active", 64'(active_op), 64'(4'b0000));
      chk("rst_hwdata", 64'(HWDATAM), 64'(wdata_op[DW-1:0]));

      // single transfer from port 2
      do_reset();
      set_port(2, 1, 1, 32'h2000_0010, 2'b10, 3'b000, 0, 32'hDEAD_BEEF);
      step();
      chk("single_active", 64'(active_op), 64'(4'b0100));
      chk("single_addr", 64'(HADDRM), 64'(32'h2000_0010));
      step();
      set_port(2, 0, 0, 32'h0, 2'b00, 3'b000, 0, 32'hDEAD_BEEF);
      #1;
      chk("single_wdata", 64'(HWDATAM), 64'(32'hDEAD_BEEF));
      step();

      burst_hold(0);
      burst_hold(2);

      // locked sequence from port 1 with HSEL dropping
      do_reset();
      set_port(1, 1, 1, $urandom, 2'b10, 3'b000, 1, $urandom);
      step();
      chk("lock_grant1", 64'(active_op), 64'(4'b0010));
      step();
      set_port(1, 0, 0, $urandom, 2'b00, 3'b000, 1, $urandom);
      set_port(0, 1, 1, $urandom, 2'b10, 3'b000, 0, $urandom);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("lock_hold_active", 64'(active_op), 64'(4'b0010));
         chk("lock_mastlock", 64'(HMASTLOCKM), 64'(1'b1));
      end
      set_port(1, 0, 0, $urandom, 2'b00, 3'b000, 0, $urandom);
      step();
      chk("lock_release_active", 64'(active_op), 64'(4'b0001));

      // all ports requesting singles
      do_reset();
      for (int p = 0; p < NP; p++)
         set_port(p, 1, 1, $urandom, 2'b10, 3'b000, 0, $urandom);
      for (int k = 0; k < 5; k++) begin
         step();
`ifdef AHB_OS_ROUND_ROBIN_EN
         exp_act = 4'b0001 << (k % NP);
`else
         exp_act = 4'b0001;
`endif
         chk("arb_order", 64'(active_op), 64'(exp_act));
      end

      // early-terminated INCR8 on port 3
      do_reset();
      set_port(3, 1, 1, 32'h3000_0000, 2'b10, 3'b101, 0, $urandom);
      step();
      chk("early_grant3", 64'(active_op), 64'(4'b1000));
      step();
      set_port(1, 1, 1, $urandom, 2'b10, 3'b000, 0, $urandom);
      for (int b = 1; b <= 2; b++) begin
         set_port(3, 1, 1, 32'h3000_0000 + 32'(4*b), 2'b11, 3'b101, 0, $urandom);
         step();
         chk("early_hold", 64'(active_op), 64'(4'b1000));
      end
      set_port(3, 1, 1, 32'h3000_0100, 2'b10, 3'b000, 0, $urandom);
      step();
      chk("early_reload_hold", 64'(active_op), 64'(4'b1000));
      set_port(3, 0, 0, 32'h0, 2'b00, 3'b000, 0, $urandom);
      step();
      chk("early_regrant", 64'(active_op), 64'(4'b0010));

      // random traffic with one asynchronous reset in the middle
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NP; p++) begin
            sel_op[p]        = 1'($urandom_range(0, 1));
            held_tran_op[p]  = 1'($urandom_range(0, 1));
            addr_op[p*AW +: AW] = $urandom;
            trans_op[p*2 +: 2]  = 2'($urandom_range(0, 3));
            burst_op[p*3 +: 3]  = 3'($urandom_range(0, 7));
            size_op[p*3 +: 3]   = 3'($urandom_range(0, 7));
            prot_op[p*4 +: 4]   = 4'($urandom_range(0, 15));
            master_op[p*4 +: 4] = 4'($urandom_range(0, 15));
            write_op[p]      = 1'($urandom_range(0, 1));
            mastlock_op[p]   = ($urandom_range(0, 7) == 0);
            wdata_op[p*DW +: DW] = $urandom;
         end
         HREADYOUTM = ($urandom_range(0, 3) != 0);
         if (c == 200) begin
            HRESETn = 1'b0;
            #1;
            chk("async_rst_active", 64'(active_op), 64'(4'b0000));
            chk("async_rst_ready", 64'(HREADYMUXM), 64'(1'b1));
            chk("async_rst_hsel", 64'(HSELM), 64'(1'b0));
            model_reset();
            @(negedge HCLK);
            HRESETn = 1'b1;
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
